rs_issue_scheduler: RTL and testbench

Controller for a bank of NUM_RS reservation stations sharing one pipelined ALU.
- Dispatch: allocates a free RS to each dispatched instruction.
- Issue: picks one ready RS per cycle, round-robin, and sends it to the ALU.
- Completion: tracks issued ops through the ALU latency, requests the CDB, and frees the RS once the result is granted onto the CDB.
- Sits between dispatch/ROB, the RS bank, the ALU and the CDB arbiter.

---
 rtl/rs_issue_scheduler.sv | 158 +++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler: allocates free RS entries, issues ready ones round-robin
// to a pipelined ALU, and frees each entry once its result is granted onto the CDB.
`ifndef ROB_TAG_BITS
`define ROB_TAG_BITS 4
`endif

module rs_issue_scheduler #(
  parameter int NUM_RS   = 4,
  parameter int FU_LAT   = 2,
  parameter int TAG_BITS = `ROB_TAG_BITS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         dispatch_valid,
  input  logic [NUM_RS-1:0]            rs_avail_in,
  input  logic [NUM_RS-1:0]            rs_ready_in,
  input  logic [NUM_RS*TAG_BITS-1:0]   rs_tag_in,
  input  logic                         cdb_gnt,
  input  logic                         rob_clear,
  output logic [NUM_RS-1:0]            rs_load_out,
  output logic                         dispatch_stall,
  output logic [NUM_RS-1:0]            rs_use_enable_out,
  output logic                         issue_valid,
  output logic [$clog2(NUM_RS)-1:0]    issue_idx,
  output logic [TAG_BITS-1:0]          issue_tag,
  output logic                         cdb_req,
  output logic [TAG_BITS-1:0]          cdb_tag,
  output logic [NUM_RS-1:0]            rs_free_out
);

  localparam int IDX_W = $clog2(NUM_RS);
  localparam int LAST  = FU_LAT - 1;

  logic [NUM_RS-1:0]   issued_q, issued_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [FU_LAT-1:0]   s_vld_q, s_vld_d;
  logic [IDX_W-1:0]    s_idx_q [FU_LAT];
  logic [IDX_W-1:0]    s_idx_d [FU_LAT];
  logic [TAG_BITS-1:0] s_tag_q [FU_LAT];
  logic [TAG_BITS-1:0] s_tag_d [FU_LAT];
  logic [NUM_RS-1:0]   rs_free_q, rs_free_d;

  logic [NUM_RS-1:0]   alloc_cand, iss_cand;
  logic                alloc_found, iss_found, stall, issue_fire, complete;
  logic [IDX_W-1:0]    alloc_idx, iss_idx, rr_next;
  logic [TAG_BITS-1:0] iss_tag;

  function automatic logic [NUM_RS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign alloc_cand = rs_avail_in & ~issued_q;
  assign iss_cand   = rs_ready_in & ~rs_avail_in & ~issued_q;
  assign stall      = s_vld_q[LAST] && !cdb_gnt;
  assign issue_fire = reset && !stall && !rob_clear && iss_found;
  assign complete   = s_vld_q[LAST] && cdb_gnt && !rob_clear;
  assign iss_tag    = rs_tag_in[int'(iss_idx)*TAG_BITS +: TAG_BITS];
  assign rr_next    = (iss_idx == IDX_W'(NUM_RS - 1)) ? '0 : iss_idx + 1'b1;

  // Lowest-index free entry for allocation
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (alloc_cand[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  // Round-robin search from rr_ptr; modulo done by subtraction so any NUM_RS works
  always_comb begin
    int j;
    j         = 0;
    iss_found = 1'b0;
    iss_idx   = '0;
    for (int k = NUM_RS - 1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_RS) j = j - NUM_RS;
      if (iss_cand[j]) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    rs_load_out       = (reset && dispatch_valid && !rob_clear && alloc_found) ? onehot(alloc_idx) : '0;
    dispatch_stall    = reset && dispatch_valid && !alloc_found;
    issue_valid       = issue_fire;
    issue_idx         = issue_fire ? iss_idx : '0;
    issue_tag         = issue_fire ? iss_tag : '0;
    rs_use_enable_out = issue_fire ? onehot(iss_idx) : '0;
    cdb_req           = reset && !rob_clear && s_vld_q[LAST];
    cdb_tag           = reset ? s_tag_q[LAST] : '0;
    rs_free_out       = reset ? rs_free_q : '0;
  end

  always_comb begin
    issued_d  = issued_q;
    rr_ptr_d  = rr_ptr_q;
    s_vld_d   = s_vld_q;
    s_idx_d   = s_idx_q;
    s_tag_d   = s_tag_q;
    rs_free_d = '0;
    if (rob_clear) begin
      s_vld_d   = '0;
      issued_d  = '0;
      rr_ptr_d  = '0;
      rs_free_d = '1;
    end else begin
      if (complete) begin
        rs_free_d                 = onehot(s_idx_q[LAST]);
        issued_d[s_idx_q[LAST]]   = 1'b0;
      end
      if (issue_fire) begin
        issued_d[iss_idx] = 1'b1;
        rr_ptr_d          = rr_next;
      end
      // ALU pipeline advances only when the last stage is not blocked on the CDB
      if (!stall) begin
        for (int k = 1; k < FU_LAT; k++) begin
          s_vld_d[k] = s_vld_q[k-1];
          s_idx_d[k] = s_idx_q[k-1];
          s_tag_d[k] = s_tag_q[k-1];
        end
        s_vld_d[0] = issue_fire;
        s_idx_d[0] = iss_idx;
        s_tag_d[0] = iss_tag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      issued_q  <= '0;
      rr_ptr_q  <= '0;
      s_vld_q   <= '0;
      rs_free_q <= '0;
      for (int k = 0; k < FU_LAT; k++) begin
        s_idx_q[k] <= '0;
        s_tag_q[k] <= '0;
      end
    end else begin
      issued_q  <= issued_d;
      rr_ptr_q  <= rr_ptr_d;
      s_vld_q   <= s_vld_d;
      rs_free_q <= rs_free_d;
      for (int k = 0; k < FU_LAT; k++) begin
        s_idx_q[k] <= s_idx_d[k];
        s_tag_q[k] <= s_tag_d[k];
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler (NUM_RS=4, FU_LAT=2, TAG_BITS=4).
module tb_rs_issue_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        dispatch_valid;
  logic [3:0]  rs_avail_in, rs_ready_in;
  logic [15:0] rs_tag_in;
  logic        cdb_gnt, rob_clear;
  logic [3:0]  rs_load_out, rs_use_enable_out, rs_free_out;
  logic        dispatch_stall, issue_valid, cdb_req;
  logic [1:0]  issue_idx;
  logic [3:0]  issue_tag, cdb_tag;

  int tests = 0;
  int fails = 0;

  rs_issue_scheduler #(.NUM_RS(4), .FU_LAT(2), .TAG_BITS(4)) dut (
    .clock(clock), .reset(reset), .dispatch_valid(dispatch_valid),
    .rs_avail_in(rs_avail_in), .rs_ready_in(rs_ready_in), .rs_tag_in(rs_tag_in),
    .cdb_gnt(cdb_gnt), .rob_clear(rob_clear), .rs_load_out(rs_load_out),
    .dispatch_stall(dispatch_stall), .rs_use_enable_out(rs_use_enable_out),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_tag(issue_tag),
    .cdb_req(cdb_req), .cdb_tag(cdb_tag), .rs_free_out(rs_free_out)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    rs_ready_in = 4'b0000;
    cdb_gnt     = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0; dispatch_valid = 1'b1; rs_avail_in = 4'b1111; rs_ready_in = 4'b0000;
    rs_tag_in = 16'h4321; cdb_gnt = 1'b1; rob_clear = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cyc();
      tests++;
      if ({rs_load_out, dispatch_stall, issue_valid, cdb_req, rs_free_out} !== 11'b0) begin
        fails++;
        $display("FAIL reset_outputs cyc%0d: load=%b stall=%b iv=%b req=%b free=%b, required all 0",
                 c, rs_load_out, dispatch_stall, issue_valid, cdb_req, rs_free_out);
      end
    end
    cyc();
    reset = 1'b1;
    #1;
    tests++;
    if (rs_load_out !== 4'b0001 || dispatch_stall !== 1'b0) begin
      fails++;
      $display("FAIL first_alloc: load=%b stall=%b, required 0001/0", rs_load_out, dispatch_stall);
    end
    dispatch_valid = 1'b0;
  endtask

  task automatic test_issue_order();
    logic [1:0] exp_idx [3];
    logic [3:0] exp_tag [5];
    logic       exp_req [5];
    logic [3:0] exp_free [6];
    exp_idx  = '{2'd0, 2'd1, 2'd2};
    exp_tag  = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
    exp_req  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_free = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
    cyc();
    rs_avail_in = 4'b1000; rs_ready_in = 4'b0111; rs_tag_in = 16'h0321; cdb_gnt = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin rs_ready_in = 4'b0000; #1; end
      if (c < 3) begin
        tests++;
        if (issue_valid !== 1'b1 || issue_idx !== exp_idx[c] || issue_tag !== 4'(exp_idx[c] + 1)
            || rs_use_enable_out !== 4'(1 << exp_idx[c])) begin
          fails++;
          $display("FAIL issue_order c%0d: iv=%b idx=%0d tag=%0d use=%b, required idx %0d",
                   c, issue_valid, issue_idx, issue_tag, rs_use_enable_out, exp_idx[c]);
        end
      end
      if (c < 5) begin
        tests++;
        if (cdb_req !== exp_req[c] || (exp_req[c] && cdb_tag !== exp_tag[c])) begin
          fails++;
          $display("FAIL cdb_seq c%0d: req=%b tag=%0d, required req=%b tag=%0d",
                   c, cdb_req, cdb_tag, exp_req[c], exp_tag[c]);
        end
      end
      tests++;
      if (rs_free_out !== exp_free[c]) begin
        fails++;
        $display("FAIL free_seq c%0d: free=%b, required %b", c, rs_free_out, exp_free[c]);
      end
      cyc();
    end
  endtask

  task automatic test_round_robin();
    rs_avail_in = 4'b0000; rs_ready_in = 4'b0010; rs_tag_in = 16'h4321; cdb_gnt = 1'b1;
    #1;
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd1) begin
      fails++;
      $display("FAIL rr_setup: iv=%b idx=%0d, required 1/1", issue_valid, issue_idx);
    end
    cyc();
    rs_ready_in = 4'b1011;
    #1;
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd3 || issue_tag !== 4'd4) begin
      fails++;
      $display("FAIL rr_from2: iv=%b idx=%0d tag=%0d, required 1/3/4", issue_valid, issue_idx, issue_tag);
    end
    cyc();
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd0 || rs_use_enable_out !== 4'b0001) begin
      fails++;
      $display("FAIL rr_wrap: iv=%b idx=%0d use=%b, required 1/0/0001", issue_valid, issue_idx, rs_use_enable_out);
    end
    cyc();
    drain();
  endtask

  task automatic test_backpressure();
    rs_ready_in = 4'b0001; cdb_gnt = 1'b1;
    #1;
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd0) begin
      fails++;
      $display("FAIL bp_issue0: iv=%b idx=%0d, required 1/0", issue_valid, issue_idx);
    end
    cyc();
    rs_ready_in = 4'b0010;
    #1;
    tests++;
    if (issue_valid !== 1'b1 || issue_idx !== 2'd1) begin
      fails++;
      $display("FAIL bp_issue1: iv=%b idx=%0d, required 1/1", issue_valid, issue_idx);
    end
    cyc();
    rs_ready_in = 4'b0110; cdb_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (cdb_req !== 1'b1 || cdb_tag !== 4'd1 || issue_valid !== 1'b0 || rs_free_out !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold c%0d: req=%b tag=%0d iv=%b free=%b, required 1/1/0/0000",
                 c, cdb_req, cdb_tag, issue_valid, rs_free_out);
      end
      cyc();
    end
    cdb_gnt = 1'b1;
    #1;
    tests++;
    if (cdb_req !== 1'b1 || issue_valid !== 1'b1 || issue_idx !== 2'd2 || issue_tag !== 4'd3) begin
      fails++;
      $display("FAIL bp_release: req=%b iv=%b idx=%0d tag=%0d, required 1/1/2/3",
               cdb_req, issue_valid, issue_idx, issue_tag);
    end
    cyc();
    rs_ready_in = 4'b0000;
    #1;
    tests++;
    if (rs_free_out !== 4'b0001 || cdb_tag !== 4'd2) begin
      fails++;
      $display("FAIL bp_free: free=%b tag=%0d, required 0001/2", rs_free_out, cdb_tag);
    end
    drain();
  endtask

  task automatic test_flush();
    rs_ready_in = 4'b0001; cdb_gnt = 1'b1;
    cyc();
    rs_ready_in = 4'b0010;
    cyc();
    rs_ready_in = 4'b0100; rob_clear = 1'b1; dispatch_valid = 1'b1; rs_avail_in = 4'b1000;
    #1;
    tests++;
    if (issue_valid !== 1'b0 || cdb_req !== 1'b0 || rs_use_enable_out !== 4'b0000 || rs_load_out !== 4'b0000) begin
      fails++;
      $display("FAIL flush_cycle: iv=%b req=%b use=%b load=%b, required all 0",
               issue_valid, cdb_req, rs_use_enable_out, rs_load_out);
    end
    cyc();
    rob_clear = 1'b0; rs_ready_in = 4'b0000; dispatch_valid = 1'b0;
    #1;
    tests++;
    if (rs_free_out !== 4'b1111 || cdb_req !== 1'b0) begin
      fails++;
      $display("FAIL flush_free: free=%b req=%b, required 1111/0", rs_free_out, cdb_req);
    end
    cyc();
    tests++;
    if (rs_free_out !== 4'b0000) begin
      fails++;
      $display("FAIL gnt_no_req: free=%b, required 0000", rs_free_out);
    end
  endtask

  task automatic test_no_free();
    rs_avail_in = 4'b0000; dispatch_valid = 1'b1;
    #1;
    tests++;
    if (dispatch_stall !== 1'b1 || rs_load_out !== 4'b0000) begin
      fails++;
      $display("FAIL no_free: stall=%b load=%b, required 1/0000", dispatch_stall, rs_load_out);
    end
    rs_avail_in = 4'b0110;
    #1;
    tests++;
    if (dispatch_stall !== 1'b0 || rs_load_out !== 4'b0010) begin
      fails++;
      $display("FAIL alloc_lowest: stall=%b load=%b, required 0/0010", dispatch_stall, rs_load_out);
    end
    dispatch_valid = 1'b0; rs_avail_in = 4'b0000;
  endtask

  task automatic test_reset_midflight();
    cyc();
    rs_ready_in = 4'b0001; cdb_gnt = 1'b1;
    cyc();
    rs_ready_in = 4'b0000;
    cyc();
    tests++;
    if (cdb_req !== 1'b1 || cdb_tag !== 4'd1) begin
      fails++;
      $display("FAIL mid_req: req=%b tag=%0d, required 1/1", cdb_req, cdb_tag);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (cdb_req !== 1'b0) begin
      fails++;
      $display("FAIL mid_gate: req=%b, required 0", cdb_req);
    end
    cyc();
    reset = 1'b1;
    #1;
    tests++;
    if (rs_free_out !== 4'b0000 || cdb_req !== 1'b0) begin
      fails++;
      $display("FAIL mid_discard: free=%b req=%b, required 0000/0", rs_free_out, cdb_req);
    end
  endtask

  initial begin
    test_reset();
    test_issue_order();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_no_free();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
